// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port req/ack arbiter sharing the single-port data memory.
// Build option DM_ARB_FIXED_PRIO_EN: port 0 always wins a tie (default build is round-robin).
module dm_arbiter #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_din,
   input  logic [DATA_W-1:0] dm_dout,
   output logic              busy,
   output logic              owner
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              last_gnt_q, last_gnt_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              winner;

   always_comb begin
      winner = 1'b0;
      if (m0_req && m1_req) begin
`ifdef DM_ARB_FIXED_PRIO_EN
         winner = 1'b0;
`else
         winner = ~last_gnt_q;
`endif
      end else if (m1_req) begin
         winner = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      addr_d     = addr_q;
      din_d      = din_q;
      last_gnt_d = last_gnt_q;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      case (state_q)
         S_IDLE: begin
            if (m0_req || m1_req) begin
               state_d    = S_ACCESS;
               last_gnt_d = winner;
               we_d       = winner ? m1_we    : m0_we;
               addr_d     = winner ? m1_addr  : m0_addr;
               din_d      = winner ? m1_wdata : m0_wdata;
            end
         end
         S_ACCESS: begin
            state_d = S_RESP;
            // Read data is captured per port so the other port's last result is kept.
            if (!we_q) begin
               if (last_gnt_q) rdata1_d = dm_dout;
               else            rdata0_d = dm_dout;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         we_q       <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         last_gnt_q <= 1'b1;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         last_gnt_q <= last_gnt_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

   // Gating with rstn keeps an aborted write from reaching memory.
   assign dm_we    = (state_q == S_ACCESS) && we_q && rstn;
   assign dm_addr  = addr_q;
   assign dm_din   = din_q;
   assign m0_ack   = (state_q == S_RESP) && !last_gnt_q;
   assign m1_ack   = (state_q == S_RESP) &&  last_gnt_q;
   assign m0_rdata = rdata0_q;
   assign m1_rdata = rdata1_q;
   assign busy     = (state_q == S_ACCESS) || (state_q == S_RESP);
   assign owner    = last_gnt_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_dm_arbiter;

`ifdef DM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [6:0]  m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_ack, m1_ack;
   logic [31:0] m0_rdata, m1_rdata;
   logic        dm_we;
   logic [6:0]  dm_addr;
   logic [31:0] dm_din, dm_dout;
   logic        busy, owner;

   always #5 clk = ~clk;

   dm_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
      .clk(clk), .rstn(rstn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout),
      .busy(busy), .owner(owner)
   );

   // Memory seen by the DUT, with combinational read.
   logic [31:0] mem [0:127];
   logic        mem_clr;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 128; i++) mem[i] <= '0;
      end else if (dm_we) begin
         mem[dm_addr] <= dm_din;
      end
   end
   assign dm_dout = mem[dm_addr];

   // Reference model state.
   logic [31:0] mmem [0:127];
   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          n0, n1;
   logic        mlast;
   bit          pend [2];
   int          start_c [2];
   logic        p_we [2];
   logic [6:0]  p_addr [2];
   logic [31:0] p_wdata [2];
   logic        hr0 [4];
   logic        hr1 [4];

   task automatic nc();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int p, input logic req, input logic we,
                        input logic [6:0] a, input logic [31:0] d);
      if (p == 0) begin
         m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
      end else begin
         m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
      end
   endtask

   // Single uncontended transfer starting from IDLE; leaves the arbiter idle again.
   task automatic m_xfer(input int p, input logic we, input logic [6:0] a, input logic [31:0] d);
      drive(p, 1'b1, we, a, d);
      nc();
      nc();
      chk($sformatf("xfer%0d_ack", p), 32'(p == 1 ? m1_ack : m0_ack), 32'd1);
      chk($sformatf("xfer%0d_other_ack", p), 32'(p == 1 ? m0_ack : m1_ack), 32'd0);
      if (we) mmem[a] = d;
      else chk($sformatf("xfer%0d_rdata", p), (p == 1 ? m1_rdata : m0_rdata), mmem[a]);
      nc();
      drive(p, 1'b0, 1'b0, 7'd0, 32'd0);
      nc();
   endtask

   // One cycle of randomized traffic: check any ack against the model, then update requesters.
   task automatic rand_cycle(input bit allow_new);
      logic ack [2];
      logic hp [2];
      logic expw;
      int   d;
      ack[0] = m0_ack;
      ack[1] = m1_ack;
      d = (cyc - 2) & 3;
      hp[0] = hr0[d];
      hp[1] = hr1[d];
      chk("rand_ack_onehot", 32'(ack[0] & ack[1]), 32'd0);
      for (int p = 0; p < 2; p++) begin
         if (ack[p]) begin
            chk($sformatf("rand_ack%0d_pending", p), 32'(pend[p]), 32'd1);
            chk("rand_busy_at_ack", 32'(busy), 32'd1);
            chk($sformatf("rand_req%0d_at_grant", p), 32'(hp[p]), 32'd1);
            if (hp[0] && hp[1]) expw = FIXED ? 1'b0 : ~mlast;
            else                expw = hp[1];
            chk("rand_grant", 32'(p), 32'(expw));
            mlast = (p == 1);
            if (p_we[p]) mmem[p_addr[p]] = p_wdata[p];
            else chk($sformatf("rand_rdata%0d", p), (p == 1 ? m1_rdata : m0_rdata), mmem[p_addr[p]]);
            if (!(FIXED && p == 1))
               chk($sformatf("rand_latency%0d", p), 32'((cyc - start_c[p]) <= 5), 32'd1);
            pend[p] = 1'b0;
            drive(p, 1'b0, 1'b0, 7'd0, 32'd0);
         end else if (!pend[p] && allow_new && $urandom_range(0, 1) == 1) begin
            pend[p]    = 1'b1;
            start_c[p] = cyc;
            p_we[p]    = 1'($urandom_range(0, 1));
            p_addr[p]  = 7'($urandom_range(0, 15));
            p_wdata[p] = $urandom();
            drive(p, 1'b1, p_we[p], p_addr[p], p_wdata[p]);
         end
      end
      hr0[cyc & 3] = m0_req;
      hr1[cyc & 3] = m1_req;
   endtask

   initial begin
      rstn    = 1'b0;
      mem_clr = 1'b1;
      drive(0, 1'b0, 1'b0, 7'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 7'd0, 32'd0);
      for (int i = 0; i < 128; i++) mmem[i] = '0;
      nc(); nc(); nc();
      mem_clr = 1'b0;

      // Reset state
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_m0_ack", 32'(m0_ack), 32'd0);
      chk("rst_m1_ack", 32'(m1_ack), 32'd0);
      chk("rst_m0_rdata", m0_rdata, 32'd0);
      chk("rst_m1_rdata", m1_rdata, 32'd0);
      chk("rst_dm_addr", 32'(dm_addr), 32'd0);
      chk("rst_dm_din", dm_din, 32'd0);
      chk("rst_owner", 32'(owner), 32'd1);
      chk("rst_dm_we", 32'(dm_we), 32'd0);

      // Write then read back through port 0
      rstn = 1'b1;
      drive(0, 1'b1, 1'b1, 7'd5, 32'hDEADBEEF);
      chk("t1_c0_dm_we", 32'(dm_we), 32'd0);
      nc();
      chk("t1_c1_dm_we", 32'(dm_we), 32'd1);
      chk("t1_c1_dm_addr", 32'(dm_addr), 32'd5);
      chk("t1_c1_dm_din", dm_din, 32'hDEADBEEF);
      chk("t1_c1_busy", 32'(busy), 32'd1);
      chk("t1_c1_owner", 32'(owner), 32'd0);
      chk("t1_c1_m0_ack", 32'(m0_ack), 32'd0);
      nc();
      chk("t1_c2_m0_ack", 32'(m0_ack), 32'd1);
      chk("t1_c2_dm_we", 32'(dm_we), 32'd0);
      nc();
      drive(0, 1'b0, 1'b0, 7'd0, 32'd0);
      chk("t1_c3_m0_ack", 32'(m0_ack), 32'd0);
      chk("t1_c3_busy", 32'(busy), 32'd0);
      chk("t1_mem5", mem[5], 32'hDEADBEEF);
      mmem[5] = 32'hDEADBEEF;
      nc();
      m_xfer(0, 1'b0, 7'd5, 32'd0);
      chk("t1_read_rdata", m0_rdata, 32'hDEADBEEF);

      // Preload; the final port-1 write leaves port 0 next in line on a tie
      m_xfer(0, 1'b1, 7'd3, 32'h33);
      m_xfer(0, 1'b1, 7'd1, 32'h11);
      m_xfer(1, 1'b1, 7'd2, 32'h22);

      // Both ports requesting continuously for 12 cycles
      drive(0, 1'b1, 1'b0, 7'd1, 32'd0);
      drive(1, 1'b1, 1'b0, 7'd2, 32'd0);
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < 12; k++) begin
         logic e0, e1;
         if (k != 0) nc();
         e0 = (k % 3 == 2) && (FIXED || ((k / 3) % 2 == 0));
         e1 = (k % 3 == 2) && !FIXED && ((k / 3) % 2 == 1);
         chk($sformatf("t2_m0_ack_c%0d", k), 32'(m0_ack), 32'(e0));
         chk($sformatf("t2_m1_ack_c%0d", k), 32'(m1_ack), 32'(e1));
         if (e0) chk($sformatf("t2_m0_rdata_c%0d", k), m0_rdata, 32'h11);
         if (e1) chk($sformatf("t2_m1_rdata_c%0d", k), m1_rdata, 32'h22);
         n0 += int'(m0_ack);
         n1 += int'(m1_ack);
      end
      nc();
      drive(0, 1'b0, 1'b0, 7'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 7'd0, 32'd0);
      chk("t2_m0_ack_count", 32'(n0), FIXED ? 32'd4 : 32'd2);
      chk("t2_m1_ack_count", 32'(n1), FIXED ? 32'd0 : 32'd2);
      nc();

      // Port 1 arrives while port 0 is in flight
      drive(0, 1'b1, 1'b0, 7'd2, 32'd0);
      nc();
      drive(1, 1'b1, 1'b0, 7'd5, 32'd0);
      chk("t3_c1_owner", 32'(owner), 32'd0);
      chk("t3_c1_dm_addr", 32'(dm_addr), 32'd2);
      nc();
      chk("t3_c2_m0_ack", 32'(m0_ack), 32'd1);
      chk("t3_c2_m1_ack", 32'(m1_ack), 32'd0);
      chk("t3_c2_m0_rdata", m0_rdata, 32'h22);
      nc();
      drive(0, 1'b0, 1'b0, 7'd0, 32'd0);
      chk("t3_c3_busy", 32'(busy), 32'd0);
      nc();
      chk("t3_c4_busy", 32'(busy), 32'd1);
      chk("t3_c4_owner", 32'(owner), 32'd1);
      chk("t3_c4_dm_addr", 32'(dm_addr), 32'd5);
      chk("t3_c4_m1_ack", 32'(m1_ack), 32'd0);
      nc();
      chk("t3_c5_m1_ack", 32'(m1_ack), 32'd1);
      chk("t3_c5_m0_ack", 32'(m0_ack), 32'd0);
      chk("t3_c5_m1_rdata", m1_rdata, 32'hDEADBEEF);
      nc();
      drive(1, 1'b0, 1'b0, 7'd0, 32'd0);
      nc();

      // Port 0 read leaves port 1 read data untouched
      drive(0, 1'b1, 1'b0, 7'd3, 32'd0);
      nc();
      chk("t5_c1_owner", 32'(owner), 32'd0);
      chk("t5_c1_busy", 32'(busy), 32'd1);
      chk("t5_c1_m1_rdata", m1_rdata, 32'hDEADBEEF);
      nc();
      chk("t5_c2_m0_ack", 32'(m0_ack), 32'd1);
      chk("t5_c2_m1_ack", 32'(m1_ack), 32'd0);
      chk("t5_c2_m0_rdata", m0_rdata, 32'h33);
      chk("t5_c2_m1_rdata", m1_rdata, 32'hDEADBEEF);
      nc();
      drive(0, 1'b0, 1'b0, 7'd0, 32'd0);
      nc();

      // Reset asserted during a port-1 write access
      drive(1, 1'b1, 1'b1, 7'd9, 32'h1234);
      nc();
      chk("t4_c1_dm_we", 32'(dm_we), 32'd1);
      chk("t4_c1_dm_addr", 32'(dm_addr), 32'd9);
      rstn = 1'b0;
      drive(1, 1'b0, 1'b0, 7'd0, 32'd0);
      #1;
      chk("t4_dm_we_gated", 32'(dm_we), 32'd0);
      nc();
      chk("t4_m1_ack", 32'(m1_ack), 32'd0);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_owner", 32'(owner), 32'd1);
      chk("t4_dm_addr", 32'(dm_addr), 32'd0);
      chk("t4_dm_din", dm_din, 32'd0);
      chk("t4_m0_rdata", m0_rdata, 32'd0);
      chk("t4_m1_rdata", m1_rdata, 32'd0);
      chk("t4_mem9", mem[9], 32'd0);
      rstn = 1'b1;
      nc();

      // Randomized traffic from both ports
      mlast  = 1'b1;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         hr0[i] = 1'b0;
         hr1[i] = 1'b0;
      end
      for (int k = 0; k < 900; k++) begin
         nc();
         rand_cycle(k < 600);
         if (k >= 600 && !pend[0] && !pend[1]) break;
      end
      chk("rand_drain", 32'({pend[0], pend[1]}), 32'd0);
      for (int i = 0; i < 16; i++)
         chk($sformatf("rand_mem%0d", i), mem[i], mmem[i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
